mac_dot_scheduler: RTL
======================

MAC_DOT_SCHEDULER -- requirements
Module: mac_dot_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one multi_precision_mac.
REQ-002 SHALL have parameter MAX_LEN, default 256, maximum operand pairs per job; LEN_W = $clog2(MAX_LEN+1).
REQ-003 SHALL have parameter ACC_W, default 32, integer accumulator width, equal to the MAC's ACCUMULATOR_WIDTH.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 job_valid  in  NUM_REQ  per-requester job request.
REQ-007 job_ready  out  NUM_REQ  one-hot job accept.
REQ-008 job_mode  in  2*NUM_REQ  per-requester precision mode (00 INT8, 01 INT4, 10 FP8, 11 treated as INT8).
REQ-009 job_len  in  LEN_W*NUM_REQ  per-requester operand-pair count.
REQ-010 op_valid / op_ready  in / out  NUM_REQ each  per-requester operand-beat handshake.
REQ-011 op_a, op_b  in  8*NUM_REQ each  per-requester operand bytes.
REQ-012 mac_mode 2, mac_a 8, mac_b 8, mac_enable 1, mac_clear 1  out  drive the MAC.
REQ-013 mac_acc_int  in  ACC_W;  mac_acc_fp16  in  16  MAC accumulator outputs.
REQ-014 res_valid / res_ready  out / in  1 each  result handshake.
REQ-015 res_id  out  $clog2(NUM_REQ) (min 1)  owner of result; res_int  out  ACC_W;  res_fp16  out  16;  res_err  out  1.

Function
REQ-016 FSM states IDLE, CLEAR, STREAM, DRAIN, RESULT.
REQ-017 IDLE: pick a requester with job_valid by round-robin from pointer; assert its job_ready for one cycle; latch id, mode, len (len > MAX_LEN saturates to MAX_LEN); go to CLEAR.
REQ-018 Round-robin pointer SHALL move to granted index + 1 (mod NUM_REQ) on each grant; pointer = 0 after reset.
REQ-019 CLEAR: mac_clear = 1 for exactly one cycle, mac_enable = 0; go to STREAM, or to DRAIN if len = 0.
REQ-020 STREAM: op_ready = 1 only for the owner; each owner op_valid & op_ready beat drives mac_a/mac_b and mac_enable = 1 in the same cycle; no other cycle asserts mac_enable.
REQ-021 Beat counter SHALL go to DRAIN on the beat where count reaches len; no extra beat accepted.
REQ-022 mac_mode SHALL hold the latched mode from CLEAR through DRAIN; 0 in IDLE.
REQ-023 DRAIN: exactly 2 cycles (MAC input register + accumulate), then capture mac_acc_int/mac_acc_fp16 into res_int/res_fp16; go to RESULT.
REQ-024 RESULT: res_valid = 1 holding res_id/res_int/res_fp16/res_err stable until res_ready; on handshake go to IDLE; new grants only in IDLE.
REQ-025 job_ready, op_ready, mac_enable, mac_clear SHALL be 0 in every state except as stated above.

Reset
REQ-026 rst SHALL force IDLE, pointer 0, counters 0, and all outputs 0, including mid-STREAM; the next job's CLEAR restores the MAC.

Configuration
REQ-027 With MAC_SCHED_TIMEOUT_EN defined: a 16-bit idle counter in STREAM, reset on each beat; at 1024 consecutive beatless cycles go to DRAIN with res_err = 1.
REQ-028 Without MAC_SCHED_TIMEOUT_EN: STREAM waits indefinitely; res_err tied 0.

Structure
REQ-029 Shared package mac_pkg SHALL hold the mode encodings, the FSM state enum, and the DRAIN latency constant (2).
REQ-030 Round-robin grant SHALL be sub-module rr_arbiter (NUM_REQ requests, advance strobe, one-hot grant).

Verification
REQ-031 Req0 INT8, len 4, a=0x03, b=0xFE each beat -> res_int = -24, res_id = 0, 1 CLEAR cycle, 2 DRAIN cycles.
REQ-032 Req1 FP8, len 2, a=b=0x38 (1.0) -> res_fp16 = 0x4000, res_int = 0.
REQ-033 Both job_valid high continuously after reset -> grants 0,1,0,1; op_ready never to non-owner.
REQ-034 res_ready low 10 cycles -> res_valid and data stable, no job_ready; then IDLE after handshake.
REQ-035 rst mid-STREAM after 2 of 4 beats -> all outputs 0 next cycle; next job INT4 len 1, a=b=0x07 -> res_int = 49.
REQ-036 (MAC_SCHED_TIMEOUT_EN) len 3, stop after 1 beat -> res_err = 1 after 1024 idle cycles plus 2 DRAIN.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC precision modes, scheduler FSM states and timing constants
package mac_pkg;
  typedef enum logic [1:0] {MODE_INT8 = 2'b00, MODE_INT4 = 2'b01, MODE_FP8 = 2'b10} mode_e;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_e;
  localparam int DRAIN_CYCLES = 2;
  localparam int TIMEOUT_CYCLES = 1024;
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return m == 2'b11 ? MODE_INT8 : m;
  endfunction
endpackage

// File: rtl/mac_dot_scheduler_if.sv
// mac_dot_scheduler_if: job, operand, MAC and result signals; master is the scheduler side
interface mac_dot_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 256,
  parameter int ACC_W = 32
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] job_valid, job_ready;
  logic [2*NUM_REQ-1:0] job_mode;
  logic [LEN_W*NUM_REQ-1:0] job_len;
  logic [NUM_REQ-1:0] op_valid, op_ready;
  logic [8*NUM_REQ-1:0] op_a, op_b;
  logic [1:0] mac_mode;
  logic [7:0] mac_a, mac_b;
  logic mac_enable, mac_clear;
  logic [ACC_W-1:0] mac_acc_int;
  logic [15:0] mac_acc_fp16;
  logic res_valid, res_ready;
  logic [ID_W-1:0] res_id;
  logic [ACC_W-1:0] res_int;
  logic [15:0] res_fp16;
  logic res_err;
  modport master (
    input job_valid, job_mode, job_len, op_valid, op_a, op_b, mac_acc_int, mac_acc_fp16, res_ready,
    output job_ready, op_ready, mac_mode, mac_a, mac_b, mac_enable, mac_clear,
    output res_valid, res_id, res_int, res_fp16, res_err
  );
  modport slave (
    output job_valid, job_mode, job_len, op_valid, op_a, op_b, mac_acc_int, mac_acc_fp16, res_ready,
    input job_ready, op_ready, mac_mode, mac_a, mac_b, mac_enable, mac_clear,
    input res_valid, res_id, res_int, res_fp16, res_err
  );
endinterface

// File: rtl/mac_dot_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves just past the winner on advance
module rr_arbiter #(
  parameter int N = 2,
  parameter int ID_W = N > 1 ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] ptr;
  logic found;
  always_comb begin
    grant = '0;
    grant_id = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        grant_id = ID_W'((int'(ptr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance && found) ptr <= int'(grant_id) == N - 1 ? '0 : grant_id + ID_W'(1);
  end
endmodule

// File: rtl/mac_dot_scheduler.sv
// mac_dot_scheduler: round-robin dot-product jobs onto one shared MAC; define MAC_SCHED_TIMEOUT_EN for the STREAM stall timeout
module mac_dot_scheduler
  import mac_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 256,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  mac_dot_scheduler_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_e state, nxt;
  logic [NUM_REQ-1:0] req, grant;
  logic [ID_W-1:0] gid, id;
  logic [1:0] mode, dcnt;
  logic [LEN_W-1:0] len, cnt, req_len;
  logic [ACC_W-1:0] res_int;
  logic [15:0] res_fp16;
  logic advance, beat, last_beat, drain_done, timeout;
  assign req = bus.job_valid & {NUM_REQ{state == IDLE}};
  assign advance = |grant;
  assign req_len = bus.job_len[LEN_W*int'(gid) +: LEN_W];
  assign beat = state == STREAM && bus.op_valid[id];
  assign last_beat = beat && cnt + LEN_W'(1) == len;
  assign drain_done = state == DRAIN && dcnt == 2'(DRAIN_CYCLES - 1);
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk), .rst(rst), .req(req), .advance(advance), .grant(grant), .grant_id(gid)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = advance ? CLEAR : IDLE;
      CLEAR:   nxt = len == '0 ? DRAIN : STREAM;
      STREAM:  nxt = last_beat || timeout ? DRAIN : STREAM;
      DRAIN:   nxt = drain_done ? RESULT : DRAIN;
      RESULT:  nxt = bus.res_ready ? IDLE : RESULT;
      default: nxt = IDLE;
    endcase
    bus.job_ready = grant;
    bus.op_ready = state == STREAM ? NUM_REQ'(1) << id : '0;
    bus.mac_enable = beat;
    bus.mac_clear = state == CLEAR;
    bus.mac_mode = state inside {CLEAR, STREAM, DRAIN} ? mode : 2'b00;
    bus.mac_a = beat ? bus.op_a[8*int'(id) +: 8] : 8'h00;
    bus.mac_b = beat ? bus.op_b[8*int'(id) +: 8] : 8'h00;
    bus.res_valid = state == RESULT;
    bus.res_id = id;
    bus.res_int = res_int;
    bus.res_fp16 = res_fp16;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id <= '0;
      mode <= 2'b00;
      len <= '0;
      cnt <= '0;
      dcnt <= 2'b00;
      res_int <= '0;
      res_fp16 <= '0;
    end else begin
      state <= nxt;
      if (advance) begin
        id <= gid;
        mode <= norm_mode(bus.job_mode[2*int'(gid) +: 2]);
        len <= req_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : req_len;
      end
      cnt <= state == STREAM ? cnt + LEN_W'(beat) : '0;
      dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'b00;
      if (drain_done) begin
        res_int <= bus.mac_acc_int;
        res_fp16 <= bus.mac_acc_fp16;
      end
    end
  end
`ifdef MAC_SCHED_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic err;
  assign timeout = state == STREAM && !beat && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
  assign bus.res_err = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      err <= 1'b0;
    end else begin
      idle_cnt <= state == STREAM && !beat ? idle_cnt + 16'd1 : '0;
      err <= advance ? 1'b0 : err | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.res_err = 1'b0;
`endif
endmodule
